// File: rtl/mips_exec_ctrl.sv
// Run/step/halt sequencer for a five-stage MIPS pipeline: global advance enable, flush and cycle count.
// Optional cycle limit (max_cycles input, sticky timeout) is built when MIPS_EXEC_CYCLE_LIMIT_EN is defined.
module mips_exec_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             halt_detect,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
    input  logic [CNT_W-1:0] max_cycles,
`endif
    output logic             timeout,
    output logic [2:0]       dbg_state
);

    // Command handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_HALT  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         drain_cnt_q, drain_cnt_d;
    logic               pipe_en_q, pipe_en_d;
    logic               pipe_flush_q, pipe_flush_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               cmd_acc;
    logic               cnt_clr;
    logic               limit_hit;

`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
    logic timeout_q, timeout_d;

    assign limit_hit = (max_cycles != '0) && pipe_en_q &&
                       (cycle_count_q == max_cycles - CNT_W'(1));
`else
    assign limit_hit = 1'b0;
`endif

    assign cmd_acc = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        pipe_flush_d = 1'b0;
        cnt_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN:   state_d = ST_RUN;
                        OP_STEP:  state_d = ST_STEP;
                        OP_CLEAR: begin
                            pipe_flush_d = 1'b1;
                            cnt_clr      = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // A halt instruction in ID outranks a host HALT so in-flight work still retires.
                if (halt_detect) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (limit_hit) begin
                    state_d = ST_IDLE;
                end else if (cmd_acc && (cmd_op == OP_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_detect) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q <= 4'd1) begin
                    state_d     = ST_DONE;
                    drain_cnt_d = 4'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (cmd_acc && (cmd_op == OP_CLEAR)) begin
                    state_d      = ST_IDLE;
                    pipe_flush_d = 1'b1;
                    cnt_clr      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        pipe_en_d   = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_DONE);

        cycle_count_d = cycle_count_q;
        if (cnt_clr) begin
            cycle_count_d = '0;
        end else if (pipe_en_q && (cycle_count_q != {CNT_W{1'b1}})) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
    end

`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
    always_comb begin
        timeout_d = timeout_q;
        if (cnt_clr) begin
            timeout_d = 1'b0;
        end else if ((state_q == ST_RUN) && !halt_detect && limit_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) timeout_q <= 1'b0;
        else        timeout_q <= timeout_d;
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= 4'd0;
            pipe_en_q     <= 1'b0;
            pipe_flush_q  <= 1'b1;
            cmd_ready_q   <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            pipe_en_q     <= pipe_en_d;
            pipe_flush_q  <= pipe_flush_d;
            cmd_ready_q   <= cmd_ready_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign pipe_en     = pipe_en_q;
    assign pipe_flush  = pipe_flush_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign cycle_count = cycle_count_q;
    assign dbg_state   = state_q;

endmodule
